exec_unit_pipe: RTL

Parametrised, pipelined execute stage for the processor datapath, sitting between decode and memory. It accepts one operation per cycle under a valid/ready handshake and computes the ALU result with signed-overflow and error flags. It resolves conditional and unconditional branch/jump targets into a next-PC and redirect flag. Results are registered; MUL runs as an iterative multi-cycle operation under a small FSM, with back-pressure to decode.

---
 rtl/exec_unit_pipe_if.sv | 34 +++
 rtl/exec_unit_pipe.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/exec_unit_pipe_if.sv
// Purpose: handshake and data bundle between decode, the execute stage and memory.
// Ports: in_valid/in_ready + op/br_type/a/b/imm/pc_inc from decode;
//        out_valid/out_ready + result/pc_next/redirect/ovf/err toward memory.
interface exec_unit_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [2:0]       br_type;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] pc_inc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] pc_next;
  logic             redirect;
  logic             ovf;
  logic             err;

  // Driver side: decode plus the consumer of results.
  modport master (
    output in_valid, op, br_type, a, b, imm, pc_inc, out_ready,
    input  in_ready, out_valid, result, pc_next, redirect, ovf, err
  );

  // Execute stage side.
  modport slave (
    input  in_valid, op, br_type, a, b, imm, pc_inc, out_ready,
    output in_ready, out_valid, result, pc_next, redirect, ovf, err
  );
endinterface

// File: rtl/exec_unit_pipe.sv
// Purpose: pipelined execute stage - ALU with ovf/err flags, branch/jump resolution,
//          iterative shift-add MUL under a two-state FSM.
// Latency: 1 cycle for non-MUL ops; MUL completes WIDTH edges after the accept edge.
// Backpressure: in_ready = IDLE && (!out_valid || out_ready); outputs frozen while
//          out_valid && !out_ready; decode is stalled for the whole MUL.
// Ports: clk, rst_n (async active-low), bus (exec_unit_pipe_if.slave).
module exec_unit_pipe #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  exec_unit_pipe_if.slave      bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;   // counter must hold WIDTH itself

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SRA = 4'd7;
  localparam logic [3:0] OP_ROL = 4'd8;
  localparam logic [3:0] OP_SLT = 4'd9;
  localparam logic [3:0] OP_SEQ = 4'd10;
  localparam logic [3:0] OP_SLE = 4'd11;
  localparam logic [3:0] OP_MUL = 4'd12;

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand, mplier, acc, pc_hold;

  logic             out_valid_q, redirect_q, ovf_q, err_q;
  logic [WIDTH-1:0] result_q, pc_next_q;

  logic                 accept, mul_done, legal_mul;
  logic [SHW-1:0]       sh;
  logic [WIDTH-1:0]     sum, diff, alu_res, tgt, acc_step;
  logic [2*WIDTH-1:0]   rol_tmp;
  logic                 alu_ovf, take, op_err;

  assign bus.in_ready  = (state == IDLE) && (!out_valid_q || bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.pc_next   = pc_next_q;
  assign bus.redirect  = redirect_q;
  assign bus.ovf       = ovf_q;
  assign bus.err       = err_q;

  assign accept    = bus.in_valid && bus.in_ready;
  assign op_err    = (bus.op > OP_MUL) || (bus.br_type == 3'd7) ||
                     ((bus.op == OP_MUL) && (bus.br_type != 3'd0));
  assign legal_mul = (bus.op == OP_MUL) && !op_err;
  assign mul_done  = (state == MUL) && (cnt == CW'(1));

  assign sh      = bus.b[SHW-1:0];
  assign sum     = bus.a + bus.b;
  assign diff    = bus.a - bus.b;
  // Rotate: upper half of the doubled word shifted left.
  assign rol_tmp = {bus.a, bus.a} << sh;
  assign acc_step = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND: alu_res = bus.a & bus.b;
      OP_OR:  alu_res = bus.a | bus.b;
      OP_XOR: alu_res = bus.a ^ bus.b;
      OP_SLL: alu_res = bus.a << sh;
      OP_SRL: alu_res = bus.a >> sh;
      OP_SRA: alu_res = $signed(bus.a) >>> sh;
      OP_ROL: alu_res = rol_tmp[2*WIDTH-1:WIDTH];
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) <  $signed(bus.b))};
      OP_SEQ: alu_res = {{(WIDTH-1){1'b0}}, (bus.a == bus.b)};
      OP_SLE: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) <= $signed(bus.b))};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    take = 1'b0;
    tgt  = bus.pc_inc + bus.imm;
    case (bus.br_type)
      3'd1: take = (bus.a == '0);
      3'd2: take = (bus.a != '0);
      3'd3: take = bus.a[WIDTH-1];
      3'd4: take = !bus.a[WIDTH-1];
      3'd5: take = 1'b1;
      3'd6: begin
        take = 1'b1;
        tgt  = bus.a + bus.imm;
      end
      default: take = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && legal_mul) state_nxt = MUL;
      MUL:  if (mul_done)            state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      pc_hold     <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      pc_next_q   <= '0;
      redirect_q  <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // Consume first; a load on the same edge overrides it (no bubble).
      if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;

      if (accept && !legal_mul) begin
        out_valid_q <= 1'b1;
        err_q       <= op_err;
        result_q    <= op_err ? '0 : alu_res;
        ovf_q       <= op_err ? 1'b0 : alu_ovf;
        redirect_q  <= op_err ? 1'b0 : take;
        pc_next_q   <= (!op_err && take) ? tgt : bus.pc_inc;
      end

      if (accept && legal_mul) begin
        mcand   <= bus.a;
        mplier  <= bus.b;
        acc     <= '0;
        cnt     <= CW'(WIDTH);
        pc_hold <= bus.pc_inc;
      end

      if (state == MUL) begin
        acc    <= acc_step;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CW'(1);
        if (mul_done) begin
          out_valid_q <= 1'b1;
          result_q    <= acc_step;
          pc_next_q   <= pc_hold;
          redirect_q  <= 1'b0;
          ovf_q       <= 1'b0;
          err_q       <= 1'b0;
        end
      end
    end
  end
endmodule
